menu_cursor_ctrl: RTL
=====================

# menu_cursor_ctrl

Sequencer for the on-screen selection pointer in battle and menu screens. It turns raw button levels into debounced, rate-limited cursor moves over a COLS×ROWS grid of menu slots. It drives the pointer sprite's anchor (x0, y0) and emits one-cycle confirm/cancel pulses to the game FSM. Sits between the button synchronisers and the pointer renderer in the VGA clock domain.

## Interface
Parameters:
- NUM_ITEMS, 4: number of menu slots; must be a multiple of COLS, at most 16.
- COLS, 2: grid columns. ROWS = NUM_ITEMS/COLS.
- X_BASE, 10'd400: x0 of slot (0,0).
- Y_BASE, 9'd380: y0 of slot (0,0).
- X_STEP, 10'd120: x pitch between columns.
- Y_STEP, 9'd40: y pitch between rows.
- LOCK_CYCLES, 2_500_000: input lockout after an accepted event; 22-bit counter.

Ports:
- clk  in  1  pixel/system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  menu active; when low, no events are accepted.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- btn_up, btn_down, btn_left, btn_right, btn_a, btn_b  in  1 each  already-synchronised button levels, active-high.
- x0  out  10  pointer anchor x, to the renderer.
- y0  out  9  pointer anchor y, to the renderer.
- sel_idx  out  4  current slot = row*COLS + col.
- confirm  out  1  one-cycle pulse, A accepted.
- cancel  out  1  one-cycle pulse, B accepted.
- busy  out  1  high while in LOCK.

## Operation
- Edge detect: a prev register per button; rise = btn & ~prev. prev updates every cycle in every state, including OFF and LOCK. A held button therefore never produces a second event.
- States:
  - OFF: entered at reset and whenever enable=0, from any state. Lock counter is cleared. Goes to READY when enable=1.
  - READY: on the first cycle with any rise, accepts exactly one event, loads lock counter with LOCK_CYCLES-1, and goes to LOCK.
  - LOCK: decrements the counter. Returns to READY on the cycle after the counter reads 0. All rises are discarded.
- Event priority when several rises occur in the same cycle: A > B > up > down > left > right. Only the winner acts.
- Actions:
  - A: confirm pulse.
  - B: cancel pulse.
  - up: row = (row==0) ? ROWS-1 : row-1.
  - down: row = (row==ROWS-1) ? 0 : row+1.
  - left: same wrap rule on col over COLS.
  - right: same wrap rule on col over COLS.
- Row/col are retained across OFF. Only rst zeroes them.
- Position:
  - Target registers tx = X_BASE + col*X_STEP and ty = Y_BASE + row*Y_STEP are updated in the cycle after the index changes.
  - x0/y0 load tx/ty only on a cycle with frame_start=1, so the sprite never tears mid-frame.
  - Arithmetic is truncated to 10/9 bits. Parameters guarantee no overflow; the bench asserts it.
- Reset values: state OFF, row=col=0, sel_idx=0, tx=x0=X_BASE, ty=y0=Y_BASE, confirm=cancel=busy=0, lock counter 0, all prev=0.

## Timing
- Rise visible at cycle n (in READY):
  - row/col/sel_idx update at n+1.
  - confirm/cancel high during n+1 only.
  - busy high from n+1 through n+LOCK_CYCLES.
  - READY again at n+LOCK_CYCLES+1.
- tx/ty valid at n+2. x0/y0 change at the first frame_start at or after n+2, registered one cycle later.
- A rise arriving on the same cycle LOCK ends (counter=0) is discarded.
- enable falling during LOCK: OFF next cycle, busy=0, and no pending pulse is emitted.
- rst mid-lockout or mid-pulse: all outputs return to reset values next cycle.
- frame_start coincident with a tx update: x0 takes the old tx. The new value appears at the next frame_start.

## Structure
- Shared game package holds:
  - the state enum {OFF, READY, LOCK};
  - the event-priority encoding (EV_NONE, EV_A, EV_B, EV_UP, EV_DOWN, EV_LEFT, EV_RIGHT);
  - the default screen-layout constants X_BASE, Y_BASE, X_STEP and Y_STEP.
- One sub-module, btn_edge, holds the six prev registers and the priority encoder, and outputs a single event code. Everything else lives in menu_cursor_ctrl.

## Test plan
All scenarios use the defaults with LOCK_CYCLES=4 and frame_start every 20 cycles.
1. Reset, then enable=1, no buttons -> sel_idx=0, x0=400, y0=380, busy=0, no pulses.
2. Press right -> sel_idx=1 next cycle; busy for 4 cycles; after the next frame_start, x0=520, y0=380. Press down after lock -> sel_idx=3, y0=420.
3. Wrap: from sel_idx=0 press up -> sel_idx=2, y0=420. Then left -> sel_idx=3, x0=520.
4. btn_a and btn_down rise in the same cycle -> exactly one confirm pulse, sel_idx unchanged. Hold btn_a 50 cycles -> no second pulse.
5. Lockout: press right, then press left 2 cycles later -> left ignored, sel_idx=1. Press left at cycle 6 (READY) -> sel_idx=0.
6. Drop enable during LOCK, then raise it -> busy=0 immediately, sel_idx retained. Assert rst mid-LOCK -> all reset values next cycle.

Source files
------------

// File: rtl/menu_cursor_ctrl_pkg.sv
// rtl/menu_cursor_ctrl_pkg.sv - shared menu FSM states, event codes and screen layout constants
package menu_cursor_ctrl_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      READY = 2'd1,
      LOCK  = 2'd2
   } state_t;

   // Encoded in priority order: lower code wins when several buttons rise together
   typedef enum logic [2:0] {
      EV_NONE  = 3'd0,
      EV_A     = 3'd1,
      EV_B     = 3'd2,
      EV_UP    = 3'd3,
      EV_DOWN  = 3'd4,
      EV_LEFT  = 3'd5,
      EV_RIGHT = 3'd6
   } event_t;

   localparam logic [9:0] DEF_X_BASE = 10'd400;
   localparam logic [8:0] DEF_Y_BASE = 9'd380;
   localparam logic [9:0] DEF_X_STEP = 10'd120;
   localparam logic [8:0] DEF_Y_STEP = 9'd40;

endpackage

// File: rtl/menu_cursor_ctrl_btn_edge.sv
// rtl/menu_cursor_ctrl_btn_edge.sv - button rise detection and priority encoding into one event code
module btn_edge
   import menu_cursor_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_a,
   input  logic       btn_b,
   output logic [2:0] ev
);

   logic [5:0] btn;
   logic [5:0] prev;
   logic [5:0] rise;

   assign btn  = {btn_right, btn_left, btn_down, btn_up, btn_b, btn_a};
   assign rise = btn & ~prev;

   // prev tracks the levels unconditionally so a held button never re-fires
   always_ff @(posedge clk) begin
      if (rst) begin
         prev <= 6'd0;
      end else begin
         prev <= btn;
      end
   end

   always_comb begin
      ev = EV_NONE;
      if (rise[0])      ev = EV_A;
      else if (rise[1]) ev = EV_B;
      else if (rise[2]) ev = EV_UP;
      else if (rise[3]) ev = EV_DOWN;
      else if (rise[4]) ev = EV_LEFT;
      else if (rise[5]) ev = EV_RIGHT;
   end

endmodule

// File: rtl/menu_cursor_ctrl.sv
// rtl/menu_cursor_ctrl.sv - debounced, rate-limited menu cursor over a COLS x ROWS slot grid
module menu_cursor_ctrl
   import menu_cursor_ctrl_pkg::*;
#(
   parameter int         NUM_ITEMS   = 4,
   parameter int         COLS        = 2,
   parameter logic [9:0] X_BASE      = DEF_X_BASE,
   parameter logic [8:0] Y_BASE      = DEF_Y_BASE,
   parameter logic [9:0] X_STEP      = DEF_X_STEP,
   parameter logic [8:0] Y_STEP      = DEF_Y_STEP,
   parameter int         LOCK_CYCLES = 2_500_000
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       frame_start,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_a,
   input  logic       btn_b,
   output logic [9:0] x0,
   output logic [8:0] y0,
   output logic [3:0] sel_idx,
   output logic       confirm,
   output logic       cancel,
   output logic       busy
);

   localparam int          ROWS      = NUM_ITEMS / COLS;
   localparam logic [3:0]  ROW_LAST  = 4'(ROWS - 1);
   localparam logic [3:0]  COL_LAST  = 4'(COLS - 1);
   localparam logic [21:0] LOCK_LOAD = 22'(LOCK_CYCLES - 1);

   state_t      state;
   logic [21:0] lock_cnt;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [2:0]  ev_code;
   event_t      ev;
   logic [9:0]  tx;
   logic [8:0]  ty;

   btn_edge u_btn_edge (
      .clk       (clk),
      .rst       (rst),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .btn_a     (btn_a),
      .btn_b     (btn_b),
      .ev        (ev_code)
   );

   assign ev      = event_t'(ev_code);
   assign sel_idx = 4'(row * 4'(COLS) + col);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= OFF;
         lock_cnt <= 22'd0;
         row      <= 4'd0;
         col      <= 4'd0;
         confirm  <= 1'b0;
         cancel   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         confirm <= 1'b0;
         cancel  <= 1'b0;
         // Disable overrides every state; row/col deliberately survive it
         if (!enable) begin
            state    <= OFF;
            lock_cnt <= 22'd0;
            busy     <= 1'b0;
         end else begin
            case (state)
               OFF: begin
                  state <= READY;
               end
               READY: begin
                  if (ev != EV_NONE) begin
                     state    <= LOCK;
                     lock_cnt <= LOCK_LOAD;
                     busy     <= 1'b1;
                     case (ev)
                        EV_A:     confirm <= 1'b1;
                        EV_B:     cancel  <= 1'b1;
                        EV_UP:    row <= (row == 4'd0) ? ROW_LAST : row - 4'd1;
                        EV_DOWN:  row <= (row == ROW_LAST) ? 4'd0 : row + 4'd1;
                        EV_LEFT:  col <= (col == 4'd0) ? COL_LAST : col - 4'd1;
                        EV_RIGHT: col <= (col == COL_LAST) ? 4'd0 : col + 4'd1;
                        default:  ;
                     endcase
                  end
               end
               LOCK: begin
                  if (lock_cnt == 22'd0) begin
                     state <= READY;
                     busy  <= 1'b0;
                  end else begin
                     lock_cnt <= lock_cnt - 22'd1;
                  end
               end
               default: begin
                  state <= OFF;
               end
            endcase
         end
      end
   end

   // Targets follow the index one cycle later; the anchor only moves in vblank to avoid tearing
   always_ff @(posedge clk) begin
      if (rst) begin
         tx <= X_BASE;
         ty <= Y_BASE;
         x0 <= X_BASE;
         y0 <= Y_BASE;
      end else begin
         tx <= X_BASE + 10'(col) * X_STEP;
         ty <= Y_BASE + 9'(row) * Y_STEP;
         if (frame_start) begin
            x0 <= tx;
            y0 <= ty;
         end
      end
   end

endmodule
